// File: rtl/cpu_run_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cpu_run_ctrl_pkg                                          |
// | Purpose  : Shared encodings for the CPU execution sequencer. The     |
// |            run-state encoding is also consumed by the display mux so |
// |            it can show the current mode.                             |
// | Ports    : none (package)                                            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } run_state_t;

  localparam int ADDR_W     = 32;
  localparam int STEP_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/cpu_run_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cpu_run_ctrl_if                                           |
// | Purpose  : Board-side and core-side signals of the execution         |
// |            sequencer bundled into one interface.                     |
// | Ports    : master -> drives run_sw, step_btn, bp_en, bp_addr, pc     |
// |            slave  -> drives cpu_ce, state, halted, step_count        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface cpu_run_ctrl_if;
  import cpu_run_ctrl_pkg::*;

  logic                  run_sw;
  logic                  step_btn;
  logic                  bp_en;
  logic [ADDR_W-1:0]     bp_addr;
  logic [ADDR_W-1:0]     pc;
  logic                  cpu_ce;
  run_state_t            state;
  logic                  halted;
  logic [STEP_CNT_W-1:0] step_count;

  modport master (
    output run_sw, step_btn, bp_en, bp_addr, pc,
    input  cpu_ce, state, halted, step_count
  );

  modport slave (
    input  run_sw, step_btn, bp_en, bp_addr, pc,
    output cpu_ce, state, halted, step_count
  );

endinterface
`default_nettype wire

// File: rtl/cpu_run_ctrl_btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : btn_debounce                                              |
// | Purpose  : Two-flop synchronizer, debounce counter and rising-edge   |
// |            pulse for a raw bouncing push button. Reusable for any    |
// |            board button.                                             |
// | Ports    : clock   in  board clock                                   |
// |            reset   in  async active-high reset                       |
// |            btn_raw in  raw asynchronous button                       |
// |            press   out one-clock pulse on accepted 0->1 transition   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module btn_debounce #(
  parameter int DEB_W = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam logic [DEB_W-1:0] C_CNT_MAX = '1;

  logic             r_sync0;
  logic             r_sync1;
  logic             r_level;
  logic             r_level_d;
  logic [DEB_W-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync0   <= 1'b0;
      r_sync1   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync0   <= btn_raw;
      r_sync1   <= r_sync0;
      r_level_d <= r_level;
      // Any sample agreeing with the accepted level restarts the count, so
      // only an unbroken run of disagreeing samples can flip the level.
      if (r_sync1 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_MAX) begin
        r_level <= r_sync1;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + DEB_W'(1);
      end
    end
  end

  assign press = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cpu_run_ctrl                                              |
// | Purpose  : Execution sequencer for the single-cycle MIPS core. Turns |
// |            run switch, step button and breakpoint settings into a    |
// |            one-cycle clock enable: free-run at a divided rate,       |
// |            single-step, and PC breakpoint.                           |
// | Ports    : clock  in  board clock                                    |
// |            reset  in  async active-high reset                        |
// |            bus    slave modport of cpu_run_ctrl_if                   |
// |              run_sw, step_btn, bp_en, bp_addr, pc  (in)              |
// |              cpu_ce, state, halted, step_count     (out)             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DEB_W     = 20,
  parameter int RUN_DIV_W = 26
) (
  input  logic           clock,
  input  logic           reset,
  cpu_run_ctrl_if.slave  bus
);

  logic                  w_step_press;
  run_state_t            r_state;
  run_state_t            w_state_nxt;
  logic [RUN_DIV_W-1:0]  r_div;
  logic [RUN_DIV_W-1:0]  w_div_nxt;
  logic                  r_cpu_ce;
  logic                  w_ce_nxt;
  logic                  r_halted;
  logic [STEP_CNT_W-1:0] r_step_count;
  logic                  w_div_last;
  logic                  w_bp_hit;

  btn_debounce #(
    .DEB_W (DEB_W)
  ) u_step_deb (
    .clock   (clock),
    .reset   (reset),
    .btn_raw (bus.step_btn),
    .press   (w_step_press)
  );

  assign w_div_last = &r_div;
  // pc is the next instruction, so a hit stops before it executes.
  assign w_bp_hit   = bus.bp_en && (bus.pc == bus.bp_addr);

  always_comb begin
    w_state_nxt = r_state;
    w_ce_nxt    = 1'b0;
    w_div_nxt   = r_div;
    case (r_state)
      ST_HALT: begin
        // run_sw wins; a coincident step press is dropped.
        if (bus.run_sw) begin
          w_state_nxt = ST_RUN;
          w_div_nxt   = '0;
        end else if (w_step_press) begin
          w_state_nxt = ST_STEP;
          w_ce_nxt    = 1'b1;
        end
      end
      ST_STEP: begin
        w_state_nxt = ST_HALT;
      end
      ST_RUN: begin
        w_div_nxt = r_div + RUN_DIV_W'(1);
        if (!bus.run_sw) begin
          w_state_nxt = ST_HALT;
        end else if (w_div_last) begin
          if (w_bp_hit) begin
            w_state_nxt = ST_BREAK;
          end else begin
            w_ce_nxt = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (!bus.run_sw) begin
          w_state_nxt = ST_HALT;
        end else if (w_step_press) begin
          w_state_nxt = ST_STEP;
          w_ce_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_HALT;
      r_div        <= '0;
      r_cpu_ce     <= 1'b0;
      r_halted     <= 1'b1;
      r_step_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_cpu_ce <= w_ce_nxt;
      r_halted <= (w_state_nxt != ST_RUN);
      if (w_ce_nxt) begin
        r_step_count <= r_step_count + STEP_CNT_W'(1);
      end
    end
  end

  assign bus.cpu_ce     = r_cpu_ce;
  assign bus.state      = r_state;
  assign bus.halted     = r_halted;
  assign bus.step_count = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_cpu_run_ctrl                                           |
// | Purpose  : Self-checking bench for cpu_run_ctrl with a behavioural   |
// |            reference model and directed plus random stimulus.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_cpu_run_ctrl;

  localparam int DEB_W     = 2;
  localparam int RUN_DIV_W = 3;
  localparam int PERIOD    = 1 << RUN_DIV_W;
  localparam int DEB_RUN   = 1 << DEB_W;  // disagreeing samples needed to flip
  localparam int MD_HALT = 0, MD_RUN = 1, MD_STEP = 2, MD_BREAK = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  cpu_run_ctrl_if bus();

  cpu_run_ctrl #(
    .DEB_W     (DEB_W),
    .RUN_DIV_W (RUN_DIV_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_mode;
  int          m_phase;     // clocks spent in the current run burst, mod PERIOD
  logic [15:0] m_count;
  logic        m_ce;
  logic        m_lvl;       // accepted button level
  logic        m_press;     // press seen by the sequencer at the next edge
  logic        hist[$];     // button as sampled at recent edges, newest first
  logic [31:0] pc_model;
  int          pulses;
  logic        prev_ce;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = MD_HALT;
    m_phase = 0;
    m_count = 16'h0000;
    m_ce    = 1'b0;
    m_lvl   = 1'b0;
    m_press = 1'b0;
    hist.delete();
    for (int i = 0; i < 2 + DEB_RUN; i++) hist.push_back(1'b0);
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    logic press_now;
    logic flip;
    logic bp_hit;
    press_now = m_press;
    hist.push_front(bus.step_btn);
    void'(hist.pop_back());
    // Synchronizer delays by two edges; the level flips once DEB_RUN
    // consecutive synced samples disagree with it.
    flip = 1'b1;
    for (int i = 2; i < 2 + DEB_RUN; i++) if (hist[i] == m_lvl) flip = 1'b0;
    m_press = 1'b0;
    if (flip) begin
      m_press = hist[2] & ~m_lvl;
      m_lvl   = hist[2];
    end
    bp_hit = bus.bp_en && (bus.pc == bus.bp_addr);
    m_ce = 1'b0;
    case (m_mode)
      MD_HALT: begin
        if (bus.run_sw) begin m_mode = MD_RUN; m_phase = 0; end
        else if (press_now) begin m_mode = MD_STEP; m_ce = 1'b1; end
      end
      MD_STEP: m_mode = MD_HALT;
      MD_RUN: begin
        if (!bus.run_sw) m_mode = MD_HALT;
        else begin
          if (m_phase == PERIOD - 1) begin
            if (bp_hit) m_mode = MD_BREAK;
            else m_ce = 1'b1;
          end
          m_phase = (m_phase + 1) % PERIOD;
        end
      end
      default: begin
        if (!bus.run_sw) m_mode = MD_HALT;
        else if (press_now) begin m_mode = MD_STEP; m_ce = 1'b1; end
      end
    endcase
    if (m_ce) m_count = m_count + 16'd1;
  endtask

  task automatic check_outputs();
    check_val("state", 32'(bus.state), 32'(m_mode));
    check_val("cpu_ce", 32'(bus.cpu_ce), 32'(m_ce));
    check_val("halted", 32'(bus.halted), 32'(m_mode != MD_RUN));
    check_val("step_count", 32'(bus.step_count), 32'(m_count));
    check_val("ce_back_to_back", 32'(bus.cpu_ce & prev_ce), 32'd0);
  endtask

  task automatic cycle(input logic run, input logic btn);
    bus.run_sw   = run;
    bus.step_btn = btn;
    model_step();
    @(negedge clock);
    check_outputs();
    if (bus.cpu_ce) pulses++;
    prev_ce = bus.cpu_ce;
    if (m_ce) begin
      pc_model = pc_model + 32'd4;
      bus.pc   = pc_model;
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.run_sw   = 1'b0;
    bus.step_btn = 1'b0;
    bus.bp_en    = 1'b0;
    bus.bp_addr  = 32'h0;
    pc_model     = 32'h0;
    bus.pc       = 32'h0;
    repeat (2) @(negedge clock);
    reset   = 1'b0;
    prev_ce = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   last;
    logic run;
    logic btn;

    do_reset();
    check_val("rst_state", 32'(bus.state), 32'd0);
    check_val("rst_halted", 32'(bus.halted), 32'd1);
    check_val("rst_cpu_ce", 32'(bus.cpu_ce), 32'd0);
    check_val("rst_count", 32'(bus.step_count), 32'd0);

    // Bouncing button, then a steady hold: exactly one step.
    pulses = 0;
    for (int i = 0; i < 6; i++) cycle(1'b0, (i % 2) == 0);
    repeat (10) cycle(1'b0, 1'b1);
    check_val("bounce_pulses", 32'(pulses), 32'd1);
    check_val("bounce_count", 32'(bus.step_count), 32'd1);
    check_val("bounce_state", 32'(bus.state), 32'd0);
    pulses = 0;
    repeat (20) cycle(1'b0, 1'b1);
    check_val("hold_pulses", 32'(pulses), 32'd0);
    repeat (10) cycle(1'b0, 1'b0);

    // Free run: one enable every PERIOD clocks.
    pulses = 0;
    last   = -1;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b0);
      if (bus.cpu_ce) begin
        if (last >= 0) check_val("run_gap", 32'(i - last), 32'(PERIOD));
        last = i;
      end
    end
    check_val("run_pulses_4_or_5", 32'(pulses == 4 || pulses == 5), 32'd1);
    cycle(1'b0, 1'b0);
    check_val("run_drop_state", 32'(bus.state), 32'd0);
    pulses = 0;
    repeat (10) cycle(1'b0, 1'b0);
    check_val("run_drop_pulses", 32'(pulses), 32'd0);

    // Breakpoint at 0xC.
    pc_model    = 32'h0;
    bus.pc      = 32'h0;
    bus.bp_en   = 1'b1;
    bus.bp_addr = 32'h0000_000C;
    pulses      = 0;
    repeat (40) cycle(1'b1, 1'b0);
    check_val("bp_pulses", 32'(pulses), 32'd3);
    check_val("bp_state", 32'(bus.state), 32'd3);
    pulses = 0;
    repeat (10) cycle(1'b1, 1'b1);
    check_val("bp_step_pulses", 32'(pulses), 32'd1);
    check_val("bp_resume_state", 32'(bus.state), 32'd1);
    pulses = 0;
    repeat (20) cycle(1'b1, 1'b0);
    check_val("bp_resume_pulses", 32'(pulses), 32'd2);
    repeat (3) cycle(1'b0, 1'b0);

    // HALT: run_sw rises together with a step press.
    bus.bp_en = 1'b0;
    for (int i = 0; i < 20 && !m_press; i++) cycle(1'b0, 1'b1);
    check_val("sim_halt_press_seen", 32'(m_press), 32'd1);
    pulses = 0;
    cycle(1'b1, 1'b1);
    check_val("sim_halt_state", 32'(bus.state), 32'd1);
    cycle(1'b1, 1'b1);
    check_val("sim_halt_pulses", 32'(pulses), 32'd0);

    // BREAK: run_sw drops together with a step press.
    bus.bp_en   = 1'b1;
    bus.bp_addr = pc_model + 32'd8;
    for (int i = 0; i < 60 && m_mode != MD_BREAK; i++) cycle(1'b1, 1'b0);
    check_val("sim_brk_reached", 32'(bus.state), 32'd3);
    for (int i = 0; i < 20 && !m_press; i++) cycle(1'b1, 1'b1);
    check_val("sim_brk_press_seen", 32'(m_press), 32'd1);
    pulses = 0;
    cycle(1'b0, 1'b1);
    check_val("sim_brk_state", 32'(bus.state), 32'd0);
    cycle(1'b0, 1'b1);
    check_val("sim_brk_pulses", 32'(pulses), 32'd0);
    repeat (10) cycle(1'b0, 1'b0);
    bus.bp_en = 1'b0;

    // Asynchronous reset while an enable is high.
    for (int i = 0; i < 40 && !m_ce; i++) cycle(1'b1, 1'b0);
    check_val("arst_pre_ce", 32'(bus.cpu_ce), 32'd1);
    reset = 1'b1;
    #1;
    check_val("arst_state", 32'(bus.state), 32'd0);
    check_val("arst_cpu_ce", 32'(bus.cpu_ce), 32'd0);
    check_val("arst_halted", 32'(bus.halted), 32'd1);
    check_val("arst_count", 32'(bus.step_count), 32'd0);
    do_reset();

    // Step counter wrap.
    force dut.r_step_count = 16'hFFFF;
    #1;
    release dut.r_step_count;
    m_count = 16'hFFFF;
    check_val("wrap_preload", 32'(bus.step_count), 32'h0000_FFFF);
    repeat (10) cycle(1'b0, 1'b1);
    check_val("wrap_count", 32'(bus.step_count), 32'h0000_0000);
    repeat (10) cycle(1'b0, 1'b0);

    // Random mix of run, step and breakpoint activity.
    run = 1'b0;
    btn = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      if ($urandom_range(0, 7) == 0) btn = ~btn;
      if ($urandom_range(0, 31) == 0) begin
        bus.bp_en   = 1'($urandom_range(0, 1));
        bus.bp_addr = pc_model + 32'(4 * $urandom_range(0, 3));
      end
      cycle(run, btn);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
